fdce_bank_sched: RTL and testbench



---
 rtl/fdce_bank_sched_if.sv | 38 +++
 rtl/fdce_bank_sched.sv | 147 ++++++++++++++
 tb/tb_fdce_bank_sched.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdce_bank_sched_if.sv
// Bus between requesting control blocks, the scheduler and the register bank.
//   REQ     requester -> scheduler  per-requester write request (held until granted)
//   ADDR    requester -> scheduler  packed word addresses, requester i at [i*AW +: AW]
//   DATA    requester -> scheduler  packed write data, requester i at [i*DW +: DW]
//   CLRALL  requester -> scheduler  bulk-clear request
//   GNT     scheduler -> requester  one-hot grant pulse
//   ERR     scheduler -> requester  granted address out of range, no write done
//   BANK_CE scheduler -> bank       per-word clock enable
//   BANK_D  scheduler -> bank       common data bus
//   BUSY    scheduler -> requester  clear sweep in progress
//   DONE    scheduler -> requester  one-cycle pulse after the last sweep word
interface fdce_bank_sched_if #(
  parameter int NREQ   = 4,
  parameter int NWORDS = 8,
  parameter int AW     = 3,
  parameter int DW     = 8
);
  logic [NREQ-1:0]    REQ;
  logic [NREQ*AW-1:0] ADDR;
  logic [NREQ*DW-1:0] DATA;
  logic               CLRALL;
  logic [NREQ-1:0]    GNT;
  logic               ERR;
  logic [NWORDS-1:0]  BANK_CE;
  logic [DW-1:0]      BANK_D;
  logic               BUSY;
  logic               DONE;

  modport master (
    output REQ, ADDR, DATA, CLRALL,
    input  GNT, ERR, BANK_CE, BANK_D, BUSY, DONE
  );

  modport slave (
    input  REQ, ADDR, DATA, CLRALL,
    output GNT, ERR, BANK_CE, BANK_D, BUSY, DONE
  );
endinterface

// File: rtl/fdce_bank_sched.sv
// Write scheduler for a bank of NWORDS clock-enabled registers sharing one D bus.
// Round-robin arbitration of single-cycle word writes among NREQ requesters,
// plus a synchronous bulk-clear sweep (D=0 through CE, one word per cycle).
// All outputs are registered.
//   C      clock, rising edge
//   CLR_N  synchronous reset, active low
//   bus    slave side of fdce_bank_sched_if (requests in; grants, bank CE/D, status out)
module fdce_bank_sched #(
  parameter int NREQ   = 4,
  parameter int NWORDS = 8,
  parameter int AW     = 3,
  parameter int DW     = 8
) (
  input  logic             C,
  input  logic             CLR_N,
  fdce_bank_sched_if.slave bus
);

  localparam int unsigned NR = NREQ;
  localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] NW_L = (AW+1)'(NWORDS);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              err_q, err_d;
  logic [NWORDS-1:0] ce_q, ce_d;
  logic [DW-1:0]     d_q, d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [NREQ-1:0]   elig;
  logic              win_vld;
  logic [PW-1:0]     win;
  logic [PW-1:0]     cand;
  logic [AW-1:0]     win_addr;
  logic              arb_en;

  // Round-robin search starting just after the last winner. Requesters granted
  // this cycle are masked so a held REQ is not granted twice in a row.
  always_comb begin
    elig    = bus.REQ & ~gnt_q;
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = PW'((32'(ptr_q) + k) % NR);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
    win_addr = bus.ADDR[win*AW +: AW];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    err_d   = 1'b0;
    ce_d    = '0;
    d_d     = d_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    arb_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.CLRALL) begin
          state_d = SWEEP;
          idx_d   = '0;
          busy_d  = 1'b1;
          d_d     = '0;
          ce_d[0] = 1'b1;
        end else begin
          arb_en = 1'b1;
        end
      end
      SWEEP: begin
        if (idx_q == AW'(NWORDS - 1)) begin
          // Leaving the sweep: DONE and the first new grant share this edge.
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
          arb_en  = 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
          busy_d = 1'b1;
          d_d    = '0;
          for (int unsigned j = 0; j < NWORDS; j++) begin
            ce_d[j] = (idx_d == AW'(j));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_en && win_vld) begin
      gnt_d[win] = 1'b1;
      d_d        = bus.DATA[win*DW +: DW];
      ptr_d      = win;
      if ({1'b0, win_addr} < NW_L) begin
        for (int unsigned j = 0; j < NWORDS; j++) begin
          ce_d[j] = (win_addr == AW'(j));
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge C) begin
    if (!CLR_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      ce_q    <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      ce_q    <= ce_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.ERR     = err_q;
  assign bus.BANK_CE = ce_q;
  assign bus.BANK_D  = d_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

endmodule

// File: tb/tb_fdce_bank_sched.sv
// Bench for fdce_bank_sched: an 8-word and a 6-word instance driven by the same
// stimulus, each compared every cycle against a cycle-level behavioural model.
module tb_fdce_bank_sched;

  logic        C = 1'b0;
  logic        CLR_N;
  logic [3:0]  req;
  logic [11:0] addr;
  logic [31:0] data;
  logic        clrall;

  int passed = 0;
  int total  = 0;

  fdce_bank_sched_if #(.NREQ(4), .NWORDS(8), .AW(3), .DW(8)) bus_a ();
  fdce_bank_sched_if #(.NREQ(4), .NWORDS(6), .AW(3), .DW(8)) bus_b ();

  assign bus_a.REQ = req;  assign bus_a.ADDR = addr;  assign bus_a.DATA = data;  assign bus_a.CLRALL = clrall;
  assign bus_b.REQ = req;  assign bus_b.ADDR = addr;  assign bus_b.DATA = data;  assign bus_b.CLRALL = clrall;

  fdce_bank_sched #(.NREQ(4), .NWORDS(8), .AW(3), .DW(8)) dut_a (.C(C), .CLR_N(CLR_N), .bus(bus_a));
  fdce_bank_sched #(.NREQ(4), .NWORDS(6), .AW(3), .DW(8)) dut_b (.C(C), .CLR_N(CLR_N), .bus(bus_b));

  always #5 C = ~C;

  // pos: word being cleared this cycle, -1 when not sweeping.
  typedef struct {
    int         pos;
    int         ptr;
    logic [3:0] gnt;
    logic       err;
    logic [7:0] ce;
    logic [7:0] d;
    logic       busy;
    logic       done;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t model(mstate_t s, int nwords, logic rstn, logic [3:0] r,
                                    logic [11:0] a, logic [31:0] dat, logic ca);
    mstate_t    n;
    bit         arb;
    logic [3:0] elig;
    int         w, ad;
    n.pos = -1; n.ptr = s.ptr; n.gnt = '0; n.err = 1'b0; n.ce = '0; n.d = s.d;
    n.busy = 1'b0; n.done = 1'b0;
    if (!rstn) begin
      n.ptr = 3; n.d = '0;
      return n;
    end
    arb = 1'b1;
    if (s.pos >= 0) begin
      if (s.pos < nwords - 1) begin
        n.pos = s.pos + 1; n.busy = 1'b1; n.ce = 8'(1 << n.pos); n.d = '0; arb = 1'b0;
      end else begin
        n.done = 1'b1;
      end
    end else if (ca) begin
      n.pos = 0; n.busy = 1'b1; n.ce = 8'h01; n.d = '0; arb = 1'b0;
    end
    if (arb) begin
      elig = r & ~s.gnt;
      for (int k = 1; k <= 4; k++) begin
        w = (s.ptr + k) % 4;
        if (elig[w]) begin
          n.gnt = 4'(1 << w);
          n.d   = dat[w*8 +: 8];
          ad    = int'(a[w*3 +: 3]);
          if (ad < nwords) n.ce = 8'(1 << ad);
          else             n.err = 1'b1;
          n.ptr = w;
          break;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [22:0] pack(mstate_t m);
    return {m.gnt, m.err, m.ce, m.d, m.busy, m.done};
  endfunction

  function automatic logic [22:0] obs_a();
    return {bus_a.GNT, bus_a.ERR, bus_a.BANK_CE, bus_a.BANK_D, bus_a.BUSY, bus_a.DONE};
  endfunction

  function automatic logic [22:0] obs_b();
    return {bus_b.GNT, bus_b.ERR, 2'b00, bus_b.BANK_CE, bus_b.BANK_D, bus_b.BUSY, bus_b.DONE};
  endfunction

  task automatic step();
    ma = model(ma, 8, CLR_N, req, addr, data, clrall);
    mb = model(mb, 6, CLR_N, req, addr, data, clrall);
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    CLR_N = 1'b0; req = '0; addr = '0; data = '0; clrall = 1'b0;
    ma = '{default: '0}; mb = '{default: '0};
    ma.pos = -1; mb.pos = -1;
    step();
    step();
    total++;
    if (obs_a() !== 23'h0) $display("FAIL reset_a obs=%h exp=%h", obs_a(), 23'h0);
    else passed++;
    total++;
    if (obs_b() !== 23'h0) $display("FAIL reset_b obs=%h exp=%h", obs_b(), 23'h0);
    else passed++;
  endtask

  task automatic test_round_robin();
    CLR_N = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      addr[i*3 +: 3] = 3'(i);
      data[i*8 +: 8] = 8'hA0 + 8'(i);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus_a.GNT !== 4'(1 << i) || bus_a.BANK_CE !== 8'(1 << i) || bus_a.BANK_D !== 8'hA0 + 8'(i))
        $display("FAIL rr_%0d obs gnt=%b ce=%h d=%h exp gnt=%b ce=%h d=%h", i, bus_a.GNT,
                 bus_a.BANK_CE, bus_a.BANK_D, 4'(1 << i), 8'(1 << i), 8'hA0 + 8'(i));
      else passed++;
      total++;
      if (obs_b() !== pack(mb)) $display("FAIL rr_b_%0d obs=%h exp=%h", i, obs_b(), pack(mb));
      else passed++;
      req[i] = 1'b0;
    end
    step();
    total++;
    if (obs_a() !== pack(ma)) $display("FAIL rr_idle obs=%h exp=%h", obs_a(), pack(ma));
    else passed++;
  endtask

  task automatic test_single_hold();
    req = 4'b0100; addr[8:6] = 3'd5; data[23:16] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus_a.GNT !== ((i % 2 == 0) ? 4'b0100 : 4'b0000) ||
          bus_a.BANK_CE !== ((i % 2 == 0) ? 8'h20 : 8'h00))
        $display("FAIL hold_%0d obs gnt=%b ce=%h exp gnt=%b", i, bus_a.GNT, bus_a.BANK_CE,
                 (i % 2 == 0) ? 4'b0100 : 4'b0000);
      else passed++;
      total++;
      if (obs_a() !== pack(ma)) $display("FAIL hold_model_%0d obs=%h exp=%h", i, obs_a(), pack(ma));
      else passed++;
    end
    req = '0;
    step();
  endtask

  task automatic test_sweep();
    req = 4'b0010; clrall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      clrall = 1'b0;
      total++;
      if (bus_a.BUSY !== 1'b1 || bus_a.BANK_CE !== 8'(1 << i) || bus_a.BANK_D !== 8'h00 ||
          bus_a.GNT !== 4'b0000 || bus_a.DONE !== 1'b0)
        $display("FAIL sweep_%0d obs busy=%b ce=%h d=%h gnt=%b exp busy=1 ce=%h d=00 gnt=0000",
                 i, bus_a.BUSY, bus_a.BANK_CE, bus_a.BANK_D, bus_a.GNT, 8'(1 << i));
      else passed++;
      total++;
      if (obs_b() !== pack(mb)) $display("FAIL sweep_b_%0d obs=%h exp=%h", i, obs_b(), pack(mb));
      else passed++;
    end
    step();
    total++;
    if (bus_a.DONE !== 1'b1 || bus_a.BUSY !== 1'b0 || bus_a.GNT !== 4'b0010)
      $display("FAIL sweep_done obs done=%b busy=%b gnt=%b exp done=1 busy=0 gnt=0010",
               bus_a.DONE, bus_a.BUSY, bus_a.GNT);
    else passed++;
    total++;
    if (obs_b() !== pack(mb)) $display("FAIL sweep_done_b obs=%h exp=%h", obs_b(), pack(mb));
    else passed++;
    req = '0;
    step();
  endtask

  task automatic test_err();
    req = 4'b1000; addr[11:9] = 3'd7; data[31:24] = 8'h5A;
    step();
    total++;
    if (bus_b.GNT !== 4'b1000 || bus_b.ERR !== 1'b1 || bus_b.BANK_CE !== 6'h00)
      $display("FAIL err_b obs gnt=%b err=%b ce=%h exp gnt=1000 err=1 ce=00",
               bus_b.GNT, bus_b.ERR, bus_b.BANK_CE);
    else passed++;
    total++;
    if (obs_a() !== pack(ma)) $display("FAIL err_a obs=%h exp=%h", obs_a(), pack(ma));
    else passed++;
    req = 4'b0001; addr[2:0] = 3'd2; data[7:0] = 8'h77;
    step();
    total++;
    if (bus_b.GNT !== 4'b0001 || bus_b.ERR !== 1'b0 || bus_b.BANK_CE !== 6'h04 || bus_b.BANK_D !== 8'h77)
      $display("FAIL err_next obs gnt=%b err=%b ce=%h d=%h exp gnt=0001 err=0 ce=04 d=77",
               bus_b.GNT, bus_b.ERR, bus_b.BANK_CE, bus_b.BANK_D);
    else passed++;
    req = '0;
    step();
  endtask

  task automatic test_reset_mid_sweep();
    clrall = 1'b1;
    step();
    clrall = 1'b0;
    step();
    step();
    CLR_N = 1'b0;
    step();
    total++;
    if (obs_a() !== 23'h0) $display("FAIL midreset_a obs=%h exp=%h", obs_a(), 23'h0);
    else passed++;
    total++;
    if (obs_b() !== 23'h0) $display("FAIL midreset_b obs=%h exp=%h", obs_b(), 23'h0);
    else passed++;
    CLR_N = 1'b1; req = 4'b1111;
    step();
    total++;
    if (bus_a.GNT !== 4'b0001 || bus_a.BUSY !== 1'b0)
      $display("FAIL midreset_first obs gnt=%b busy=%b exp gnt=0001 busy=0", bus_a.GNT, bus_a.BUSY);
    else passed++;
    req = '0;
    step();
    step();
  endtask

  task automatic test_wrap();
    req = 4'b1000; addr[11:9] = 3'd1;
    step();
    req = 4'b1001;
    step();
    total++;
    if (bus_a.GNT !== 4'b0001) $display("FAIL wrap_0 obs=%b exp=%b", bus_a.GNT, 4'b0001);
    else passed++;
    req = 4'b1000;
    step();
    total++;
    if (bus_a.GNT !== 4'b1000) $display("FAIL wrap_3 obs=%b exp=%b", bus_a.GNT, 4'b1000);
    else passed++;
    total++;
    if (obs_b() !== pack(mb)) $display("FAIL wrap_b obs=%h exp=%h", obs_b(), pack(mb));
    else passed++;
    req = '0;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req    = 4'($urandom);
      addr   = 12'($urandom);
      data   = $urandom;
      clrall = ($urandom_range(0, 15) == 0);
      CLR_N  = ($urandom_range(0, 99) != 0);
      step();
      total++;
      if (obs_a() !== pack(ma)) $display("FAIL rand_a_%0d obs=%h exp=%h", i, obs_a(), pack(ma));
      else passed++;
      total++;
      if (obs_b() !== pack(mb)) $display("FAIL rand_b_%0d obs=%h exp=%h", i, obs_b(), pack(mb));
      else passed++;
      total++;
      if ($countones(bus_a.BANK_CE) > 1 || $countones(bus_a.GNT) > 1 ||
          (bus_a.BANK_CE != 0 && bus_a.GNT == 0 && !bus_a.BUSY) ||
          (bus_b.ERR && ($countones(bus_b.GNT) != 1 || bus_b.BANK_CE != 0)))
        $display("FAIL rand_inv_%0d ce=%h gnt=%b busy=%b err_b=%b ce_b=%h", i,
                 bus_a.BANK_CE, bus_a.GNT, bus_a.BUSY, bus_b.ERR, bus_b.BANK_CE);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_hold();
    test_sweep();
    test_err();
    test_reset_mid_sweep();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
